// File: rtl/mdu_pkg.sv
// Shared encodings and default latencies for the multiply/divide unit.
//   md_op_e    : operation encoding carried on op[1:0] (op[1] selects divide)
//   md_state_e : scheduler FSM state encoding
package mdu_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10
  } md_state_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;
  localparam int unsigned CNT_W           = 4;

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath for the latched operation.
//   op      : latched operation (signed/unsigned mult/div)
//   a, b    : latched rs/rt operands
//   prod    : 64-bit product {hi,lo}
//   quot    : quotient (truncated toward zero)
//   rem     : remainder (sign of dividend)
//   divzero : divisor is zero
module mdu_arith
  import mdu_pkg::*;
(
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] prod,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        divzero
);

  logic        is_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [63:0] prod_mag;
  logic [31:0] quot_mag;
  logic [31:0] rem_mag;

  // Work on magnitudes so the signed cases (including MIN / -1) are well defined.
  always_comb begin
    is_signed = (op == MD_MULT) || (op == MD_DIV);
    a_neg     = is_signed & a[31];
    b_neg     = is_signed & b[31];
    a_mag     = a_neg ? (~a + 32'd1) : a;
    b_mag     = b_neg ? (~b + 32'd1) : b;
    divzero   = (b == 32'd0);
    b_safe    = divzero ? 32'd1 : b_mag;
    prod_mag  = {32'd0, a_mag} * {32'd0, b_mag};
    quot_mag  = a_mag / b_safe;
    rem_mag   = a_mag % b_safe;
    prod      = (a_neg ^ b_neg) ? (~prod_mag + 64'd1) : prod_mag;
    quot      = (a_neg ^ b_neg) ? (~quot_mag + 32'd1) : quot_mag;
    rem       = a_neg ? (~rem_mag + 32'd1) : rem_mag;
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide scheduler owning HI/LO.
//   clk, rst       : clock, synchronous active-low reset
//   start, op      : E-stage MULT/MULTU/DIV/DIVU request and encoding
//   mthi, mtlo     : E-stage moves of rs_val into HI/LO
//   rs_val, rt_val : forwarded E-stage operands
//   intreq         : interrupt flush; drops a same-cycle E-stage command
//   md_use_d       : D-stage instruction touches the MDU or HI/LO
//   busy           : operation in flight
//   stall_md       : stall request into the hazard path (combinational)
//   hi, lo         : HI/LO registers
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        intreq,
  input  logic        md_use_d,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  md_op_e           op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic [63:0] prod;
  logic [31:0] quot;
  logic [31:0] rem;
  logic        divzero;

  mdu_arith u_arith (
    .op      (op_q),
    .a       (a_q),
    .b       (b_q),
    .prod    (prod),
    .quot    (quot),
    .rem     (rem),
    .divzero (divzero)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!intreq) begin
          if (start) begin
            op_d    = md_op_e'(op);
            a_d     = rs_val;
            b_d     = rt_val;
            cnt_d   = op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            state_d = op[1] ? ST_DIV : ST_MUL;
          end else if (mthi) begin
            hi_d = rs_val;
          end else if (mtlo) begin
            lo_d = rs_val;
          end
        end
      end
      ST_MUL: begin
        if (cnt_q == CNT_W'(1)) begin
          {hi_d, lo_d} = prod;
          cnt_d        = '0;
          state_d      = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DIV: begin
        if (cnt_q == CNT_W'(1)) begin
          // Divide by zero still burns the full latency but leaves HI/LO alone.
          if (!divzero) begin
            hi_d = rem;
            lo_d = quot;
          end
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_MULT;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  // Stall already in the start cycle so a following MFHI/MFLO waits for the commit.
  assign stall_md = md_use_d && (busy || (start && !intreq));
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: expected {hi,lo} pushed on each start,
// popped and compared when busy falls.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic        mthi;
  logic        mtlo;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        intreq;
  logic        md_use_d;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] sb_q[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  mdu_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .mthi     (mthi),
    .mtlo     (mtlo),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .intreq   (intreq),
    .md_use_d (md_use_d),
    .busy     (busy),
    .stall_md (stall_md),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model_op(input logic [1:0] o, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] ch,
                                           input logic [31:0] cl);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] q;
    logic signed [63:0] r;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    case (o)
      2'b00: model_op = sa * sb;
      2'b01: model_op = {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 32'd0) model_op = {ch, cl};
        else begin
          q = sa / sb;
          r = sa % sb;
          model_op = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) model_op = {ch, cl};
        else model_op = {a % b, a / b};
      end
    endcase
  endfunction

  // Issues one operation at the current cycle and follows it to completion.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic use_d, input logic irq_during);
    int          n;
    int          cnt;
    logic [63:0] e;
    n   = o[1] ? 10 : 5;
    cnt = 0;
    check_eq("idle_before_start", {63'd0, busy}, 64'd0);
    start    = 1'b1;
    op       = o;
    rs_val   = a;
    rt_val   = b;
    md_use_d = use_d;
    #1;
    check_eq("stall_start_cycle", {63'd0, stall_md}, {63'd0, use_d});
    e = model_op(o, a, b, m_hi, m_lo);
    sb_q.push_back(e);
    {m_hi, m_lo} = e;
    cyc();
    start  = 1'b0;
    rs_val = $urandom;
    rt_val = $urandom;
    intreq = irq_during;
    while (busy && cnt < 20) begin
      cnt++;
      if (use_d) check_eq("stall_busy", {63'd0, stall_md}, 64'd1);
      cyc();
    end
    check_eq("busy_cycles", 64'(cnt), 64'(n));
    check_eq("stall_after", {63'd0, stall_md}, 64'd0);
    if (sb_q.size() == 0) begin
      check_eq("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      check_eq("hilo_result", {hi, lo}, e);
    end
    intreq   = 1'b0;
    md_use_d = 1'b0;
  endtask

  task automatic do_mt(input logic sel_hi, input logic [31:0] v);
    check_eq("idle_before_mt", {63'd0, busy}, 64'd0);
    mthi   = sel_hi;
    mtlo   = ~sel_hi;
    rs_val = v;
    cyc();
    mthi = 1'b0;
    mtlo = 1'b0;
    if (sel_hi) m_hi = v;
    else m_lo = v;
    check_eq("mt_hilo", {hi, lo}, {m_hi, m_lo});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    rst = 1'b0; start = 1'b0; op = 2'b00; mthi = 1'b0; mtlo = 1'b0;
    rs_val = '0; rt_val = '0; intreq = 1'b0; md_use_d = 1'b0;
    m_hi = '0; m_lo = '0;
    cyc();
    cyc();
    rst = 1'b1;
    check_eq("reset_busy", {63'd0, busy}, 64'd0);
    check_eq("reset_stall", {63'd0, stall_md}, 64'd0);
    check_eq("reset_hilo", {hi, lo}, 64'd0);

    // MULT -2 * 3 with MFHI held in D
    run_op(2'b00, 32'hFFFFFFFE, 32'd3, 1'b1, 1'b0);
    check_eq("mult_const", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFFA});
    // MULTU back to back
    run_op(2'b01, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0);
    check_eq("multu_const", {hi, lo}, {32'h00000002, 32'hFFFFFFFA});
    // DIV -7 / 2
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
    check_eq("div_const", {hi, lo}, {32'hFFFFFFFF, 32'hFFFFFFFD});
    // DIVU by zero keeps preset HI/LO
    do_mt(1'b1, 32'h11);
    do_mt(1'b0, 32'h22);
    run_op(2'b11, 32'd1234, 32'd0, 1'b0, 1'b0);
    check_eq("divu_zero_const", {hi, lo}, {32'h11, 32'h22});

    // start with intreq in the same cycle is dropped
    start = 1'b1; op = 2'b00; rs_val = 32'd9; rt_val = 32'd9; intreq = 1'b1; md_use_d = 1'b1;
    #1;
    check_eq("irq_start_stall", {63'd0, stall_md}, 64'd0);
    cyc();
    start = 1'b0; intreq = 1'b0; md_use_d = 1'b0;
    check_eq("irq_start_busy", {63'd0, busy}, 64'd0);
    check_eq("irq_start_hilo", {hi, lo}, {32'h11, 32'h22});
    // mthi with intreq is dropped too
    mthi = 1'b1; rs_val = 32'h55; intreq = 1'b1;
    cyc();
    mthi = 1'b0; intreq = 1'b0;
    check_eq("irq_mthi_hilo", {hi, lo}, {32'h11, 32'h22});

    // intreq during busy DIV does not stop the commit
    run_op(2'b10, 32'd100, 32'hFFFFFFFD, 1'b1, 1'b1);
    check_eq("div_irq_const", {hi, lo}, {32'd1, 32'hFFFFFFDF});
    // MIN / -1 signed
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);

    // reset at cycle 3 of a MUL aborts without committing
    start = 1'b1; op = 2'b01; rs_val = 32'd7; rt_val = 32'd8;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    check_eq("mid_busy", {63'd0, busy}, 64'd1);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    m_hi = '0; m_lo = '0;
    check_eq("rst_mid_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_mid_hilo", {hi, lo}, 64'd0);
    cyc();
    check_eq("rst_mid_hilo_hold", {hi, lo}, 64'd0);

    do_mt(1'b1, 32'hDEADBEEF);
    check_eq("mthi_const", {32'd0, hi}, {32'd0, 32'hDEADBEEF});

    for (int i = 0; i < 10; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      run_op(ro, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    check_eq("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
